// File: rtl/ucsbece154b_fifo_pkg.sv
// Shared types and helpers for the FIFO read-side adapter.
package ucsbece154b_fifo_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 32;

   function automatic int unsigned occ_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic [DATA_WIDTH_DEF-1:0] data;
      logic                      valid;
   } stream_t;

endpackage

// File: rtl/ucsbece154b_skid_buf.sv
// Circular skid storage: one write and one read per cycle, occupancy counter,
// synchronous clear that drops everything buffered.
module ucsbece154b_skid_buf
   import ucsbece154b_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned DEPTH      = 2,
   localparam int unsigned OW        = occ_width(DEPTH),
   localparam int unsigned PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clr_i,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic [OW-1:0]         occ_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [OW-1:0]         occ_q;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (wr_en_i) wr_ptr_q <= next_ptr(wr_ptr_q);
         if (rd_en_i) rd_ptr_q <= next_ptr(rd_ptr_q);
         occ_q <= occ_q + OW'(wr_en_i) - OW'(rd_en_i);
      end
   end

   // Payload needs no reset; a clear only has to forget it via the pointers.
   always_ff @(posedge clk_i) begin
      if (wr_en_i && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && !clr_i) begin
         assert (!(wr_en_i && !rd_en_i && occ_q == OW'(DEPTH)));
         assert (!(rd_en_i && occ_q == '0));
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign occ_o     = occ_q;

endmodule

// File: rtl/ucsbece154b_fifo_reader.sv
// FIFO read adapter: credit-based pops absorb the FIFO's one-cycle read
// latency in a skid buffer and present a valid/ready stream downstream.
module ucsbece154b_fifo_reader
   import ucsbece154b_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned SKID_DEPTH = 2
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [DATA_WIDTH-1:0]            fifo_data_i,
   input  logic                             fifo_valid_i,
   output logic                             fifo_pop_o,
   input  logic                             flush_i,
   output logic [DATA_WIDTH-1:0]            out_data_o,
   output logic                             out_valid_o,
   input  logic                             out_ready_i,
   output logic [occ_width(SKID_DEPTH)-1:0] occupancy_o
);

   localparam int unsigned OW = occ_width(SKID_DEPTH);

   if (SKID_DEPTH < 2) begin : g_depth_chk
      $error("SKID_DEPTH must be >= 2 for full throughput");
   end

   logic          inflight_q, inflight_d;
   logic          consume;
   logic [OW-1:0] occ;
   logic [OW:0]   credit;

   assign out_valid_o = (occ != '0);
   assign consume     = out_valid_o && out_ready_i;

   // Slots committed after this edge: buffered + arriving - leaving.
   assign credit     = {1'b0, occ} + (OW+1)'(inflight_q) - (OW+1)'(consume);
   assign fifo_pop_o = fifo_valid_i && !flush_i && !rst_i &&
                       (credit < (OW+1)'(SKID_DEPTH));
   assign inflight_d = fifo_pop_o;

   // Pop is already suppressed during flush, so inflight clears with it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) inflight_q <= 1'b0;
      else       inflight_q <= inflight_d;
   end

   ucsbece154b_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (SKID_DEPTH)
   ) u_skid (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (flush_i),
      .wr_en_i   (inflight_q),
      .wr_data_i (fifo_data_i),
      .rd_en_i   (consume),
      .rd_data_o (out_data_o),
      .occ_o     (occ)
   );

   assign occupancy_o = occ;

endmodule

// File: tb/tb_ucsbece154b_fifo_reader.sv
// Scoreboard bench: popped FIFO words are queued as expected stream output;
// flush/reset drop every word not yet handed to the consumer.
`timescale 1ns/1ps
module tb_ucsbece154b_fifo_reader;
   import ucsbece154b_fifo_pkg::*;

   localparam int DW    = 32;
   localparam int DEPTH = 2;
   localparam int OW    = $clog2(DEPTH + 1);

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [DW-1:0] fifo_data_i = '0;
   logic          fifo_valid_i = 1'b0;
   logic          fifo_pop_o;
   logic          flush_i = 1'b0;
   logic [DW-1:0] out_data_o;
   logic          out_valid_o;
   logic          out_ready_i = 1'b0;
   logic [OW-1:0] occupancy_o;

   ucsbece154b_fifo_reader #(.DATA_WIDTH(DW), .SKID_DEPTH(DEPTH)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .fifo_data_i  (fifo_data_i),
      .fifo_valid_i (fifo_valid_i),
      .fifo_pop_o   (fifo_pop_o),
      .flush_i      (flush_i),
      .out_data_o   (out_data_o),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .occupancy_o  (occupancy_o)
   );

   always #10 clk_i = ~clk_i;

   int            tests = 0;
   int            fails = 0;
   logic [DW-1:0] fifo_q [$];
   logic          fifo_en = 1'b1;
   logic          pop_s = 1'b0;
   int            rst_req = 0;
   int            n_out = 0;
   int            max_occ = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor / scoreboard, sampled on the falling edge.
   initial begin : monitor
      logic [DW-1:0] exp_q [$];
      logic          last_pop;
      int            rst_ack;
      int            eocc;
      logic          exp_pop;
      stream_t       smp;
      last_pop = 1'b0;
      rst_ack  = 0;
      forever begin
         @(negedge clk_i);
         if (rst_req != rst_ack) begin
            exp_q.delete();
            last_pop = 1'b0;
            rst_ack  = rst_req;
         end
         smp = '{data: out_data_o, valid: out_valid_o};
         if (rst_i) begin
            check("reset_valid", {31'b0, smp.valid}, 32'd0);
            check("reset_occ", {{(32-OW){1'b0}}, occupancy_o}, 32'd0);
            check("reset_pop", {31'b0, fifo_pop_o}, 32'd0);
            exp_q.delete();
            last_pop = 1'b0;
         end else begin
            eocc = exp_q.size() - (last_pop ? 1 : 0);
            check("occupancy", {{(32-OW){1'b0}}, occupancy_o}, eocc);
            check("out_valid", {31'b0, smp.valid}, {31'b0, eocc != 0});
            if (smp.valid && out_ready_i) begin
               n_out++;
               if (exp_q.size() == 0) check("unexpected_word", smp.data, 32'hDEAD_BEEF);
               else                   check("stream_data", smp.data, exp_q.pop_front());
            end
            exp_pop = fifo_valid_i && !flush_i && (exp_q.size() < DEPTH);
            check("fifo_pop", {31'b0, fifo_pop_o}, {31'b0, exp_pop});
            if (flush_i) begin
               exp_q.delete();
               last_pop = 1'b0;
            end else begin
               if (fifo_pop_o && fifo_q.size() != 0) exp_q.push_back(fifo_q[0]);
               last_pop = fifo_pop_o;
            end
         end
      end
   end

   task automatic upd();
      fifo_valid_i = fifo_en && (fifo_q.size() != 0);
   endtask

   // One cycle: FIFO model serves last pop, new inputs at +1, settled sample at +2.
   task automatic tick(input logic rdy, input logic fl);
      @(posedge clk_i);
      #1;
      if (pop_s && fifo_q.size() != 0) fifo_data_i = fifo_q.pop_front();
      out_ready_i = rdy;
      flush_i     = fl;
      upd();
      #1;
      pop_s = fifo_pop_o;
      if (int'(occupancy_o) > max_occ) max_occ = int'(occupancy_o);
   endtask

   task automatic reset_pulse();
      #1 rst_i = 1'b1;
      rst_req++;
      #1;
      check("async_rst_valid", {31'b0, out_valid_o}, 32'd0);
      check("async_rst_occ", {{(32-OW){1'b0}}, occupancy_o}, 32'd0);
      check("async_rst_pop", {31'b0, fifo_pop_o}, 32'd0);
      rst_i = 1'b0;
      #1 pop_s = fifo_pop_o;
   endtask

   task automatic drain();
      logic done;
      done    = 1'b0;
      fifo_en = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         tick(1'b1, 1'b0);
         done = (fifo_q.size() == 0) && (occupancy_o == '0) && !pop_s;
      end
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      check("drain_done", {31'b0, done}, 32'd1);
   endtask

   initial begin : stim
      logic [9:0] pv, vv;
      int         cnt, n0;
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      #1 pop_s = fifo_pop_o;

      // Streaming
      drain();
      fifo_q = '{32'h11, 32'h22, 32'h33, 32'h44};
      n0 = n_out;
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, 1'b0);
         pv[i] = pop_s;
         vv[i] = out_valid_o;
      end
      check("stream_pop_pattern", {22'b0, pv}, 32'b00_0000_1111);
      check("stream_valid_pattern", {22'b0, vv}, 32'b00_0011_1100);
      check("stream_count", n_out - n0, 32'd4);

      // Backpressure
      drain();
      fifo_q = '{32'h11, 32'h22, 32'h33, 32'h44};
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, 1'b0);
         cnt += pop_s;
      end
      check("bp_pops", cnt, 32'd2);
      check("bp_occ", {{(32-OW){1'b0}}, occupancy_o}, 32'd2);
      check("bp_data", out_data_o, 32'h11);
      n0 = n_out;
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
      check("bp_release_count", n_out - n0, 32'd4);

      // Wrap-around with toggling ready
      drain();
      for (int w = 0; w < 10; w++) fifo_q.push_back(w);
      max_occ = 0;
      n0 = n_out;
      for (int i = 0; i < 30; i++) tick((i % 2) == 0, 1'b0);
      check("wrap_max_occ_le2", {31'b0, max_occ <= 2}, 32'd1);
      check("wrap_count", n_out - n0, 32'd10);

      // Flush with a pop in flight
      drain();
      fifo_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
      n0 = n_out;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      check("flush_pre_occ", {{(32-OW){1'b0}}, occupancy_o}, 32'd1);
      check("flush_no_pop", {31'b0, pop_s}, 32'd0);
      tick(1'b1, 1'b0);
      check("flush_valid", {31'b0, out_valid_o}, 32'd0);
      check("flush_occ", {{(32-OW){1'b0}}, occupancy_o}, 32'd0);
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
      check("flush_count", n_out - n0, 32'd5);

      // Empty then refill
      drain();
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, 1'b0);
         cnt += pop_s;
      end
      check("empty_pops", cnt, 32'd0);
      fifo_q.push_back(32'hAB);
      pv = '0;
      vv = '0;
      for (int i = 0; i < 6; i++) begin
         tick(1'b1, 1'b0);
         pv[i] = pop_s;
         vv[i] = out_valid_o;
         if (out_valid_o) check("refill_data", out_data_o, 32'hAB);
      end
      check("refill_pop_pattern", {22'b0, pv}, 32'b00_0000_0001);
      check("refill_valid_pattern", {22'b0, vv}, 32'b00_0000_0100);

      // Async reset mid-stream
      drain();
      fifo_q = '{32'h11, 32'h22, 32'h33, 32'h44};
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
      check("rst_pre_occ", {{(32-OW){1'b0}}, occupancy_o}, 32'd2);
      reset_pulse();
      n0 = n_out;
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
      check("rst_resume_count", n_out - n0, 32'd2);

      // Randomized traffic
      drain();
      for (int i = 0; i < 600; i++) begin
         if (($urandom % 2) == 0 && fifo_q.size() < 8) fifo_q.push_back($urandom);
         fifo_en = ($urandom % 5) != 0;
         tick(($urandom % 3) != 0, ($urandom % 25) == 0);
         if (($urandom % 120) == 0) reset_pulse();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ucsbece154b_fifo_reader.md
Name: ucsbece154b_fifo_reader

Overview:
- Read-side adapter for the team's synchronous FIFO. The FIFO presents registered read data one cycle after a pop.
- This block issues pops against the FIFO's valid flag and absorbs the one-cycle read latency in a small credit-controlled skid buffer.
- It presents a standard valid/ready stream to the downstream consumer (decode/execute side), in order, at full throughput.
- It also supports a synchronous flush that discards buffered and in-flight words.

Parameters:
- DATA_WIDTH, 32: width of each FIFO word and the stream payload.
- SKID_DEPTH, 2: skid buffer entries; must be >= 2 for one word/cycle throughput.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- fifo_data_i  in  DATA_WIDTH  FIFO read data; valid one cycle after the pop that selected it
- fifo_valid_i  in  1  FIFO non-empty flag
- fifo_pop_o  out  1  pop request to FIFO
- flush_i  in  1  synchronous flush of buffer and in-flight pop
- out_data_o  out  DATA_WIDTH  stream payload (buffer head)
- out_valid_o  out  1  stream valid
- out_ready_i  in  1  stream ready from consumer
- occupancy_o  out  $clog2(SKID_DEPTH+1)  current skid buffer occupancy

Behaviour:
- Interface decisions: reset is rst_i, asynchronous, active-high; clock is clk_i; all state is updated on posedge clk_i.
- Reset values:
  - occupancy_o = 0, out_valid_o = 0, inflight_q = 0, rd/wr pointers = 0.
  - out_data_o is don't-care.
  - fifo_pop_o = 0 while rst_i is high.
- State:
  - occ_q: 0..SKID_DEPTH.
  - inflight_q: 1 bit, a pop was issued last cycle.
  - Circular storage with rd_ptr/wr_ptr, wrapping at SKID_DEPTH-1 to 0.
- Consume: consume = out_valid_o && out_ready_i.
  - out_valid_o = (occ_q != 0).
  - out_data_o = mem[rd_ptr].
- Pop rule (combinational):
  - fifo_pop_o = fifo_valid_i && !flush_i && !rst_i && (occ_q + inflight_q - consume < SKID_DEPTH).
  - fifo_pop_o may depend combinationally on out_ready_i.
- Capture:
  - When inflight_q = 1, fifo_data_i is written to mem[wr_ptr] at the clock edge and wr_ptr advances.
  - The credit rule guarantees no write to a full buffer; overflow is a design error and is asserted.
- Latency:
  - Pop in cycle t gives data on fifo_data_i in t+1.
  - out_valid_o is high in t+2; no combinational bypass.
- Throughput: with SKID_DEPTH >= 2, continuous fifo_valid_i and out_ready_i give one word per cycle after the 2-cycle fill.
- Occupancy update: occ_d = occ_q + capture - consume.
  - Simultaneous capture and consume leaves occ unchanged.
  - Both pointers advance in that case.
- inflight_d = fifo_pop_o.
- Backpressure:
  - out_ready_i = 0 holds out_data_o and out_valid_o stable.
  - Pops stop once occ + inflight reaches SKID_DEPTH.
- Empty FIFO: fifo_valid_i = 0 issues no pop; buffered words still drain.
- Flush (flush_i = 1 at an edge):
  - occ, pointers and inflight_q are cleared.
  - out_valid_o = 0 the next cycle; no pop that cycle.
  - The word arriving on fifo_data_i the cycle after a flush is dropped, because inflight_q is cleared.
  - consume during the flush cycle still counts as a completed transfer for the consumer; the word is gone regardless.
  - The FIFO itself is flushed by its owner, not by this block.
- Reset mid-operation: same as flush, but asynchronous; any in-flight word is lost.
- Ordering: strict FIFO order is preserved across wrap-around of both pointers.

Decomposition:
- Shared package ucsbece154b_fifo_pkg holds:
  - DATA_WIDTH default constant.
  - Occupancy width function clog2(SKID_DEPTH+1).
  - A stream struct {data, valid} typedef.
- One sub-module, ucsbece154b_skid_buf: circular storage with write/read enables, pointers and occupancy counter.
- Credit and pop logic stays in the top.

Test Plan:
- Streaming: FIFO preloaded with 0x11,0x22,0x33,0x44, out_ready_i = 1 throughout.
  - First pop at cycle 1; out_valid_o high from cycle 3.
  - Outputs 0x11..0x44 on consecutive cycles; fifo_pop_o high for 4 consecutive cycles.
- Backpressure: same FIFO contents, out_ready_i = 0.
  - Exactly 2 pops issued; occupancy_o = 2; out_data_o held at 0x11.
  - Release ready: remaining words follow in order with no gaps or duplicates.
- Wrap-around: stream 10 words 0x0..0x9 with out_ready_i toggling 1,0,1,0.
  - Output sequence is exactly 0x0..0x9; occupancy_o never exceeds 2.
- Flush with in-flight pop: assert flush_i in the cycle after a pop while occupancy = 1.
  - Next cycle out_valid_o = 0 and occupancy_o = 0.
  - The in-flight word is never output.
- Empty/refill: fifo_valid_i = 0 for 5 cycles, then one word 0xAB pushed.
  - No pop during the empty cycles.
  - Single pop; 0xAB appears 2 cycles after the pop; out_valid_o then drops.
- Async reset mid-stream: pulse rst_i between clock edges with occupancy = 2.
  - out_valid_o, occupancy_o and fifo_pop_o are 0 immediately.
  - Streaming resumes cleanly after release.
